// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu.
package mdu_pkg;

  // MDUOp encodings shared with the E-stage controller and stall logic
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  // Default busy periods for the two latency classes
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Which busy period an accepted operation uses
  typedef enum logic {
    LAT_MULT = 1'b0,
    LAT_DIV  = 1'b1
  } lat_sel_t;

  // True for ops that occupy the unit for a multi-cycle busy period
  function automatic logic is_start_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: hit = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: hit = 1'b1;
`endif
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True for single-cycle HI/LO moves (mfhi/mflo/mthi/mtlo)
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == MDU_MFHI) || (op == MDU_MFLO) ||
           (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the multiply/divide unit: computes the full
// 64-bit {HI,LO} result an accepted operation will commit.
// Optional build macro: MDU_MADD_EN adds the accumulate/subtract forms.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [63:0] result,
  output lat_sel_t    lat_sel,
  output logic        div_zero
);

  logic [63:0]        a_sext;
  logic [63:0]        b_sext;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        hilo;
  logic               div_ovf;
  logic signed [31:0] dividend_s;
  logic signed [31:0] divisor_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        divisor_u;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  // Products, quotients and remainders for every operation in parallel;
  // the divisor is forced to 1 on divide-by-zero and on the single signed
  // overflow case so the dividers never see an undefined operand pair
  always_comb begin
    a_sext     = {{32{A[31]}}, A};
    b_sext     = {{32{B[31]}}, B};
    prod_s     = a_sext * b_sext;
    prod_u     = {32'd0, A} * {32'd0, B};
    hilo       = {HI, LO};
    div_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    dividend_s = $signed(A);
    divisor_s  = ((B == 32'd0) || div_ovf) ? 32'sd1 : $signed(B);
    quo_s      = dividend_s / divisor_s;
    rem_s      = dividend_s % divisor_s;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end
    divisor_u  = (B == 32'd0) ? 32'd1 : B;
    quo_u      = A / divisor_u;
    rem_u      = A % divisor_u;
  end

  // Select the committed result and latency class by operation
  always_comb begin
    result   = hilo;
    lat_sel  = LAT_MULT;
    div_zero = 1'b0;
    case (MDUOp)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        result   = {rem_s, quo_s};
        lat_sel  = LAT_DIV;
        div_zero = (B == 32'd0);
      end
      MDU_DIVU: begin
        result   = {rem_u, quo_u};
        lat_sel  = LAT_DIV;
        div_zero = (B == 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  result = hilo + prod_s;
      MDU_MADDU: result = hilo + prod_u;
      MDU_MSUB:  result = hilo - prod_s;
      MDU_MSUBU: result = hilo - prod_u;
`endif
      default:   result = hilo;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div
// operations through a shadow register and down-counter, and serves
// mfhi/mflo/mthi/mtlo. A flushed E-stage instruction (req) never starts
// an operation or writes HI/LO.
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  // Both latencies are assumed to be at least one cycle
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] load_count;
  logic [63:0]      shadow;
  logic             shadow_wr;
  logic [63:0]      arith_result;
  lat_sel_t         arith_lat;
  logic             arith_div_zero;
  logic             accept;
  logic             done;
  logic             move_ok;

  mdu_arith u_arith (
    .MDUOp    (MDUOp),
    .A        (A),
    .B        (B),
    .HI       (HI),
    .LO       (LO),
    .result   (arith_result),
    .lat_sel  (arith_lat),
    .div_zero (arith_div_zero)
  );

  assign accept     = start && !req && (state == ST_IDLE) && is_start_op(MDUOp);
  assign move_ok    = !req && (state == ST_IDLE);
  assign load_count = (arith_lat == LAT_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign busy       = (state == ST_BUSY);

  // Next-state logic: load the counter on accept, count down while busy,
  // and signal completion on the edge that takes the counter from 1 to 0
  always_comb begin
    state_next = state;
    count_next = count;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_BUSY;
          count_next = load_count;
        end
      end
      ST_BUSY: begin
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Capture the result at issue; a divide by zero commits nothing
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      shadow_wr <= 1'b0;
    end else if (accept) begin
      shadow    <= arith_result;
      shadow_wr <= !arith_div_zero;
    end
  end

  // Architectural HI/LO: commit at the end of the busy period, or take a
  // direct move when the unit is idle and the instruction is not flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (done) begin
      if (shadow_wr) begin
        HI <= shadow[63:32];
        LO <= shadow[31:0];
      end
    end else if (move_ok) begin
      if (MDUOp == MDU_MTHI) HI <= A;
      if (MDUOp == MDU_MTLO) LO <= A;
    end
  end

  // Move-from result reads the architectural registers only
  always_comb begin
    MDU_out = 32'd0;
    if (MDUOp == MDU_MFHI) MDU_out = HI;
    else if (MDUOp == MDU_MFLO) MDU_out = LO;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit. Expected {HI,LO} values are pushed
// to a scoreboard queue at issue and popped when the unit goes idle.
// Honors MDU_MADD_EN when the build defines it.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expq[$];

  mul_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .start   (start),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO),
    .MDU_out (MDU_out)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, return at the next negedge
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic rq);
    MDUOp = op;
    A     = a;
    B     = b;
    start = st;
    req   = rq;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    req   = 1'b0;
    MDUOp = MDU_NONE;
  endtask

  // Issue an op, measure the busy period, compare against the scoreboard
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq, input logic [63:0] exp, input int n_exp);
    int cycles;
    cycles = 0;
    expq.push_back(exp);
    applyStimulus(op, a, b, 1'b1, rq);
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_len"}, 64'(cycles), 64'(n_exp));
    checkOutput({tag, "_hilo"}, {HI, LO}, expq.pop_front());
  endtask

  initial begin
    int          cycles;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    req   = 1'b0;
    start = 1'b0;
    MDUOp = MDU_NONE;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hilo", {HI, LO}, 64'd0);
    checkOutput("reset_mdu_out", 64'(MDU_out), 64'd0);

    // Signed / unsigned multiply of -2 and 3
    runOp("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5);
    runOp("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, {32'h0000_0002, 32'hFFFF_FFFA}, 5);

    // Signed divide, divide by zero, signed overflow
    runOp("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    runOp("divu_zero", MDU_DIVU, 32'd7, 32'd0, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    runOp("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0, 32'h8000_0000}, 10);

    // Moves: single-cycle, never busy
    applyStimulus(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    MDUOp = MDU_MFHI;
    #1;
    checkOutput("mfhi", 64'(MDU_out), 64'h1234_5678);
    applyStimulus(MDU_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    MDUOp = MDU_MFLO;
    #1;
    checkOutput("mflo", 64'(MDU_out), 64'hCAFE_F00D);
    MDUOp = MDU_MULT;
    #1;
    checkOutput("mdu_out_nonmove", 64'(MDU_out), 64'd0);
    MDUOp = 4'd15;
    #1;
    checkOutput("mdu_out_undef", 64'(MDU_out), 64'd0);
    MDUOp = MDU_NONE;

    // Flushed start does nothing
    runOp("mult_req", MDU_MULT, 32'd2, 32'd3, 1'b1, {32'h1234_5678, 32'hCAFE_F00D}, 0);

    // Same op unflushed; req pulse and a stray start during busy are ignored
    expq.push_back({32'h0, 32'h6});
    applyStimulus(MDU_MULT, 32'd2, 32'd3, 1'b1, 1'b0);
    MDUOp = MDU_MFLO;
    #1;
    checkOutput("no_forward", 64'(MDU_out), 64'hCAFE_F00D);
    applyStimulus(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(MDU_MULT, 32'd7, 32'd7, 1'b1, 1'b0);
    cycles = 2;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("req_busy_len", 64'(cycles), 64'd5);
    checkOutput("req_busy_hilo", {HI, LO}, expq.pop_front());

    // Randomised unsigned multiply / divide against 64-bit arithmetic
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      runOp("rand_multu", MDU_MULTU, ra, rb, 1'b0, {32'd0, ra} * {32'd0, rb}, 5);
      rb = $urandom_range(1, 100000);
      runOp("rand_divu", MDU_DIVU, ra, rb, 1'b0, {ra % rb, ra / rb}, 10);
    end

    // Reset in busy cycle 3 of a divide aborts it
    applyStimulus(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hilo", {HI, LO}, 64'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort_hilo_later", {HI, LO}, 64'd0);

    // Accumulating multiply from HI=0, LO=0xFFFFFFFF
    applyStimulus(MDU_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    runOp("maddu", MDU_MADDU, 32'd1, 32'd1, 1'b0, {32'h1, 32'h0}, 5);
`else
    runOp("maddu_off", MDU_MADDU, 32'd1, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
